// File: rtl/imm_encode.sv
// Immediate encoder: scatters a signed immediate into the RISC-V I/S/B/J fields of a template
// instruction through a two-stage valid/ready pipeline. Optional error counter: IMM_ENCODE_ERR_CNT_EN.
module imm_encode #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [31:0]          TEMPLATE,
  input  logic [31:0]          IMM,
  input  logic [1:0]           ImmSrc,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [31:0]          INSTR,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  logic        s1_valid_reg;
  logic [31:0] s1_template_reg;
  logic [31:0] s1_imm_reg;
  logic [1:0]  s1_src_reg;

  logic        out_valid_reg;
  logic [31:0] instr_reg;
  logic        err_reg;

  logic        s2_adv;
  logic        s1_adv;
  logic [31:0] instr_next;
  logic        err_next;

  assign s2_adv   = !out_valid_reg || OUT_READY;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign IN_READY = s1_adv;

  // Range checks: every bit above the field's sign bit must match it.
  always_comb begin
    instr_next = s1_template_reg;
    err_next   = 1'b0;
    case (s1_src_reg)
      2'b00: begin
        instr_next[31:20] = s1_imm_reg[11:0];
        err_next          = s1_imm_reg[31:11] != {21{s1_imm_reg[11]}};
      end
      2'b01: begin
        instr_next[31:25] = s1_imm_reg[11:5];
        instr_next[11:7]  = s1_imm_reg[4:0];
        err_next          = s1_imm_reg[31:11] != {21{s1_imm_reg[11]}};
      end
      2'b10: begin
        instr_next[31]    = s1_imm_reg[12];
        instr_next[30:25] = s1_imm_reg[10:5];
        instr_next[11:8]  = s1_imm_reg[4:1];
        instr_next[7]     = s1_imm_reg[11];
        err_next          = (s1_imm_reg[31:12] != {20{s1_imm_reg[12]}}) || s1_imm_reg[0];
      end
      default: begin
        instr_next[31]    = s1_imm_reg[20];
        instr_next[30:21] = s1_imm_reg[10:1];
        instr_next[20]    = s1_imm_reg[11];
        instr_next[19:12] = s1_imm_reg[19:12];
        err_next          = (s1_imm_reg[31:20] != {12{s1_imm_reg[20]}}) || s1_imm_reg[0];
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_reg    <= 1'b0;
      s1_template_reg <= '0;
      s1_imm_reg      <= '0;
      s1_src_reg      <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= IN_VALID;
      if (IN_VALID) begin
        s1_template_reg <= TEMPLATE;
        s1_imm_reg      <= IMM;
        s1_src_reg      <= ImmSrc;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid_reg <= 1'b0;
      instr_reg     <= '0;
      err_reg       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        instr_reg <= instr_next;
        err_reg   <= err_next;
      end
    end
  end

  assign OUT_VALID = out_valid_reg;
  assign INSTR     = instr_reg;
  assign ERR       = err_reg;

`ifdef IMM_ENCODE_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_cnt_reg <= '0;
    end else if (out_valid_reg && OUT_READY && err_reg && !(&err_cnt_reg)) begin
      err_cnt_reg <= err_cnt_reg + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign ERR_CNT = err_cnt_reg;
`else
  assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_imm_encode.sv
// Scoreboard bench for imm_encode: expected beats queued at issue, checked on output transfer.
module tb_imm_encode;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] TEMPLATE = '0;
  logic [31:0] IMM = '0;
  logic [1:0]  ImmSrc = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] INSTR;
  logic        ERR;
  logic [15:0] ERR_CNT;

  imm_encode #(.ERR_CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .TEMPLATE(TEMPLATE), .IMM(IMM), .ImmSrc(ImmSrc), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .INSTR(INSTR), .ERR(ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    logic [1:0]  src;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic exp_t mk(logic [31:0] instr, logic err, logic [31:0] imm, logic [1:0] src);
    exp_t e;
    e.instr = instr; e.err = err; e.imm = imm; e.src = src;
    return e;
  endfunction

  // Reference encoder; legality judged by numeric range rather than bit patterns.
  function automatic exp_t model(logic [31:0] t, logic [31:0] imm, logic [1:0] s);
    exp_t e;
    int v;
    v = $signed(imm);
    e.instr = t; e.imm = imm; e.src = s; e.err = 1'b0;
    case (s)
      2'b00: begin
        e.instr[31:20] = imm[11:0];
        e.err = (v < -2048) || (v > 2047);
      end
      2'b01: begin
        e.instr[31:25] = imm[11:5];
        e.instr[11:7]  = imm[4:0];
        e.err = (v < -2048) || (v > 2047);
      end
      2'b10: begin
        e.instr[31] = imm[12]; e.instr[30:25] = imm[10:5];
        e.instr[11:8] = imm[4:1]; e.instr[7] = imm[11];
        e.err = (v < -4096) || (v > 4095) || imm[0];
      end
      default: begin
        e.instr[31] = imm[20]; e.instr[30:21] = imm[10:1];
        e.instr[20] = imm[11]; e.instr[19:12] = imm[19:12];
        e.err = (v < -(1 << 20)) || (v > (1 << 20) - 1) || imm[0];
      end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] extend(logic [31:0] i, logic [1:0] s);
    case (s)
      2'b00:   return {{20{i[31]}}, i[31:20]};
      2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  // Output monitor: scoreboard pop, stall stability and round-trip.
  bit          hold = 0;
  logic [31:0] h_instr;
  logic        h_err;
  exp_t        mon_e;

  always @(negedge CLK) begin
    if (!RST_N) begin
      hold = 0;
    end else begin
      if (hold) begin
        vectors++;
        if (OUT_VALID !== 1'b1 || INSTR !== h_instr || ERR !== h_err) begin
          miscompares++;
          $display("FAIL stall_hold: got valid=%b instr=%h err=%b, need valid=1 instr=%h err=%b",
                   OUT_VALID, INSTR, ERR, h_instr, h_err);
        end
      end
      hold = (OUT_VALID === 1'b1) && !OUT_READY;
      h_instr = INSTR;
      h_err = ERR;
      if (OUT_VALID === 1'b1 && OUT_READY) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: got instr=%h err=%b, need no beat", INSTR, ERR);
        end else begin
          mon_e = sb.pop_front();
          if (INSTR !== mon_e.instr || ERR !== mon_e.err) begin
            miscompares++;
            $display("FAIL beat: got instr=%h err=%b, need instr=%h err=%b",
                     INSTR, ERR, mon_e.instr, mon_e.err);
          end else begin
            $display("beat ok: src=%0d imm=%h instr=%h err=%b", mon_e.src, mon_e.imm, INSTR, ERR);
          end
          if (!mon_e.err) begin
            vectors++;
            if (extend(INSTR, mon_e.src) !== mon_e.imm) begin
              miscompares++;
              $display("FAIL round_trip: got %h, need %h", extend(INSTR, mon_e.src), mon_e.imm);
            end
          end
        end
      end
    end
  end

  // Offers one beat and waits for acceptance; cyc = cycles spent offering.
  task automatic send(input logic [31:0] t, input logic [31:0] imm, input logic [1:0] s,
                      input exp_t e, input bit rnd, output int cyc);
    bit acc;
    sb.push_back(e);
    TEMPLATE = t; IMM = imm; ImmSrc = s; IN_VALID = 1'b1;
    acc = 0;
    cyc = 0;
    for (int n = 0; n < 60 && !acc; n++) begin
      if (rnd) OUT_READY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      acc = IN_READY;
      @(posedge CLK); #1;
      cyc++;
    end
    IN_VALID = 1'b0;
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got IN_READY=0 for %0d cycles, need acceptance", cyc);
      void'(sb.pop_back());
    end
  endtask

  task automatic drain(output bit ok);
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge CLK); #1;
      if (sb.size() == 0 && OUT_VALID === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 RST_N = 1'b0;
    #1;
    vectors++;
    if (OUT_VALID !== 1'b0 || INSTR !== 32'h0 || ERR !== 1'b0 || ERR_CNT !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b instr=%h err=%b cnt=%h, need all zero",
               OUT_VALID, INSTR, ERR, ERR_CNT);
    end
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    #1;
    vectors++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, need 1 and 0", IN_READY, OUT_VALID);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_i;
    int cyc;
    OUT_READY = 1'b1;
    send(32'h0000_0013, 32'hFFFF_FFFF, 2'b00, mk(32'hFFF0_0013, 1'b0, 32'hFFFF_FFFF, 2'b00), 0, cyc);
    vectors++;
    if (OUT_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL i_latency_early: got OUT_VALID=%b, need 0", OUT_VALID);
    end
    @(posedge CLK); #1;
    vectors++;
    if (OUT_VALID !== 1'b1 || INSTR !== 32'hFFF0_0013 || ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL i_type: got valid=%b instr=%h err=%b, need 1 fff00013 0", OUT_VALID, INSTR, ERR);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_s_b;
    int cyc;
    bit ok;
    send(32'h0000_2023, 32'd8, 2'b01, mk(32'h0000_2423, 1'b0, 32'd8, 2'b01), 0, cyc);
    send(32'h0000_0063, 32'hFFFF_FFFC, 2'b10, mk(32'hFE00_0EE3, 1'b0, 32'hFFFF_FFFC, 2'b10), 0, cyc);
    drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL s_b_drain: got %0d pending beats, need 0", sb.size());
    end
  endtask

  task automatic test_j_roundtrip;
    int cyc;
    bit seen;
    send(32'h0000_006F, 32'd2048, 2'b11, mk(32'h0010_006F, 1'b0, 32'd2048, 2'b11), 0, cyc);
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge CLK);
      seen = OUT_VALID;
    end
    vectors++;
    if (!seen || extend(INSTR, 2'b11) !== 32'h0000_0800) begin
      miscompares++;
      $display("FAIL j_round_trip: got valid=%b ext=%h, need 1 00000800", seen, extend(INSTR, 2'b11));
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_errors;
    int cyc;
    bit ok;
    logic [15:0] exp_cnt;
    send(32'h0000_0063, 32'd3, 2'b10, mk(32'h0000_0163, 1'b1, 32'd3, 2'b10), 0, cyc);
    send(32'h0000_0013, 32'd2048, 2'b00, mk(32'h8000_0013, 1'b1, 32'd2048, 2'b00), 0, cyc);
    send(32'h0000_0013, 32'hFFFF_F800, 2'b00, mk(32'h8000_0013, 1'b0, 32'hFFFF_F800, 2'b00), 0, cyc);
    send(32'h0000_0013, 32'd2047, 2'b00, mk(32'h7FF0_0013, 1'b0, 32'd2047, 2'b00), 0, cyc);
    drain(ok);
`ifdef IMM_ENCODE_ERR_CNT_EN
    exp_cnt = 16'd2;
`else
    exp_cnt = 16'd0;
`endif
    vectors++;
    if (!ok || ERR_CNT !== exp_cnt) begin
      miscompares++;
      $display("FAIL err_cnt: got drained=%b cnt=%0d, need 1 and %0d", ok, ERR_CNT, exp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit ok;
    logic [31:0] t, imm;
    OUT_READY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      t = $urandom;
      imm = 32'($signed($urandom_range(0, 4095)) - 2048);
      send(t, imm, 2'b01, model(t, imm, 2'b01), 0, cyc);
      vectors++;
      if (cyc != 1) begin
        miscompares++;
        $display("FAIL back_to_back: got %0d cycles to accept beat %0d, need 1", cyc, k);
      end
    end
    drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL b2b_drain: got %0d pending beats, need 0", sb.size());
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    bit ok;
    exp_t e1, e2, e3;
    e1 = model(32'h0000_0013, 32'd5, 2'b00);
    e2 = model(32'h0000_2023, 32'hFFFF_FFF0, 2'b01);
    e3 = model(32'h0000_006F, 32'hFFFF_F000, 2'b11);
    OUT_READY = 1'b0;
    send(32'h0000_0013, 32'd5, 2'b00, e1, 0, cyc);
    send(32'h0000_2023, 32'hFFFF_FFF0, 2'b01, e2, 0, cyc);
    sb.push_back(e3);
    TEMPLATE = 32'h0000_006F; IMM = 32'hFFFF_F000; ImmSrc = 2'b11; IN_VALID = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      vectors++;
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || INSTR !== e1.instr) begin
        miscompares++;
        $display("FAIL backpressure: got in_ready=%b valid=%b instr=%h, need 0 1 %h",
                 IN_READY, OUT_VALID, INSTR, e1.instr);
      end
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    vectors++;
    if (IN_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL release_ready: got IN_READY=%b, need 1", IN_READY);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_drain: got %0d pending beats, need 0", sb.size());
    end
  endtask

  task automatic test_random_stall;
    int cyc;
    bit ok;
    logic [31:0] t, imm;
    logic [1:0] s;
    for (int k = 0; k < 40; k++) begin
      t = $urandom;
      s = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($signed($urandom_range(0, 4095)) - 2048);
        2: imm = 32'(($signed($urandom_range(0, 4095)) - 2048) * 2);
        default: imm = 32'(($signed($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2);
      endcase
      send(t, imm, s, model(t, imm, s), 1, cyc);
    end
    drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL random_drain: got %0d pending beats, need 0", sb.size());
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit ok;
    OUT_READY = 1'b0;
    send(32'h0000_0013, 32'd1, 2'b00, model(32'h0000_0013, 32'd1, 2'b00), 0, cyc);
    send(32'h0000_0013, 32'd2, 2'b00, model(32'h0000_0013, 32'd2, 2'b00), 0, cyc);
    RST_N = 1'b0;
    #1;
    vectors++;
    if (OUT_VALID !== 1'b0 || ERR_CNT !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got OUT_VALID=%b cnt=%h, need 0 0", OUT_VALID, ERR_CNT);
    end
    sb.delete();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    send(32'h0000_0023, 32'hFFFF_FFFF, 2'b01, mk(32'hFE00_0FA3, 1'b0, 32'hFFFF_FFFF, 2'b01), 0, cyc);
    drain(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL reset_mid_drain: got %0d pending beats, need 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_i();
    test_s_b();
    test_j_roundtrip();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_mid();
    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, need finish");
    $fatal(1, "timeout");
  end

endmodule
